// File: rtl/controller_type_defs.sv
// State encodings shared by the sequencing controllers.
package controller_type_defs;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/instr_decd_pkg.sv
// Shared instruction-path widths and types used by the fetch stage and the decoder.
package instr_decd_pkg;
  localparam int INSTR_L          = 16;
  localparam int INSTR_MEM_ADDR_L = 12;
  localparam int FETCH_FIFO_DEPTH = 4;

  typedef logic [INSTR_L-1:0]          instr_t;
  typedef logic [INSTR_MEM_ADDR_L-1:0] instr_addr_t;
endpackage

// File: rtl/instr_prefetch_fifo.sv
// First-word-fall-through prefetch FIFO: head entry is visible on rdata while vld is high.
module instr_prefetch_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     vld,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_L = $clog2(DEPTH);
  localparam logic [PTR_L:0] FULL_CNT = (PTR_L+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_L-1:0] wr_ptr;
  logic [PTR_L-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign vld     = (count != '0);
  assign do_pop  = pop && vld;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push && ((count != FULL_CNT) || do_pop);
  assign rdata   = vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push && !clr) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_L'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_L'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_L+1)'(1);
        2'b01:   count <= count - (PTR_L+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: streams an inclusive SRAM address range into a prefetch FIFO feeding the decoder.
//   state | meaning
//   IDLE  | waiting for start
//   FETCH | issuing SRAM reads while credit and run length allow
//   DRAIN | all reads issued, waiting for the decoder to accept the rest
module instr_fetch #(
  parameter int INSTR_L    = instr_decd_pkg::INSTR_L,
  parameter int ADDR_L     = instr_decd_pkg::INSTR_MEM_ADDR_L,
  parameter int FIFO_DEPTH = instr_decd_pkg::FETCH_FIFO_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_L-1:0]  start_addr,
  input  logic [ADDR_L-1:0]  end_addr,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               mem_re,
  output logic [ADDR_L-1:0]  mem_addr,
  input  logic [INSTR_L-1:0] mem_rdata,
  output logic               instr_vld,
  output logic [INSTR_L-1:0] instr,
  output logic [ADDR_L-1:0]  instr_pc,
  input  logic               instr_rdy
);
  import controller_type_defs::*;

  localparam int PTR_L = $clog2(FIFO_DEPTH);
  localparam int ENT_L = INSTR_L + ADDR_L;

  fetch_state_t        state;
  fetch_state_t        state_nxt;
  logic [ADDR_L-1:0]   pc;
  logic [ADDR_L-1:0]   inflight_addr;
  logic [ADDR_L:0]     run_len;
  logic [ADDR_L:0]     issued;
  logic [ADDR_L:0]     accepted;
  logic                inflight;
  logic [PTR_L:0]      fifo_count;
  logic [PTR_L+1:0]    used;
  logic                has_credit;
  logic [ENT_L-1:0]    fifo_rdata;
  logic                launch;
  logic                xfer;
  logic                last_xfer;

  // In-flight reads hold a FIFO slot, which is what keeps the FIFO from overflowing.
  assign used       = (PTR_L+2)'(fifo_count) + (PTR_L+2)'(inflight);
  assign has_credit = (used < (PTR_L+2)'(FIFO_DEPTH));

  assign launch    = (state == IDLE) && start && !abort;
  assign mem_re    = (state == FETCH) && !abort && (issued < run_len) && has_credit;
  assign mem_addr  = mem_re ? pc : '0;
  assign xfer      = instr_vld && instr_rdy;
  assign last_xfer = xfer && !abort && (state != IDLE) &&
                     ((accepted + (ADDR_L+1)'(1)) == run_len);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = FETCH;
      FETCH:   if (issued == run_len) state_nxt = DRAIN;
      DRAIN:   state_nxt = DRAIN;
      default: state_nxt = IDLE;
    endcase
    if (last_xfer || abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      done          <= 1'b0;
      inflight      <= 1'b0;
      inflight_addr <= '0;
      pc            <= '0;
      run_len       <= '0;
      issued        <= '0;
      accepted      <= '0;
    end else begin
      state    <= state_nxt;
      done     <= last_xfer;
      inflight <= mem_re;
      if (mem_re) inflight_addr <= pc;
      if (launch) begin
        pc       <= start_addr;
        run_len  <= {1'b0, end_addr - start_addr} + (ADDR_L+1)'(1);
        issued   <= '0;
        accepted <= '0;
      end else begin
        if (mem_re) begin
          pc     <= pc + ADDR_L'(1);
          issued <= issued + (ADDR_L+1)'(1);
        end
        if (xfer) accepted <= accepted + (ADDR_L+1)'(1);
      end
    end
  end

  instr_prefetch_fifo #(
    .WIDTH (ENT_L),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (abort),
    .push  (inflight),
    .wdata ({inflight_addr, mem_rdata}),
    .pop   (xfer),
    .rdata (fifo_rdata),
    .vld   (instr_vld),
    .count (fifo_count)
  );

  assign instr    = fifo_rdata[INSTR_L-1:0];
  assign instr_pc = fifo_rdata[INSTR_L +: ADDR_L];
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch; SRAM model returns {4'h5, addr} one cycle after mem_re.
module tb_instr_fetch;
  logic        clk;
  logic        rst;
  logic        start;
  logic [11:0] start_addr;
  logic [11:0] end_addr;
  logic        abort;
  logic        busy;
  logic        done;
  logic        mem_re;
  logic [11:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        instr_vld;
  logic [15:0] instr;
  logic [11:0] instr_pc;
  logic        instr_rdy;

  int total = 0;
  int bad   = 0;

  instr_fetch #(.INSTR_L(16), .ADDR_L(12), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .mem_re     (mem_re),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .instr_vld  (instr_vld),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_rdy  (instr_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Non-read cycles return a poison word so late or stale captures show up.
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= {4'h5, mem_addr};
    else        mem_rdata <= 16'hDEAD;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Samples from the cycle after start was taken; returns transfers, done seen, reads, first-valid sample index.
  task automatic collect(input string tag, input logic [11:0] first, output int k,
                         output int got_done, output int re_cnt, output int lat);
    int cyc;
    logic [11:0] epc;
    k = 0; got_done = 0; re_cnt = 0; lat = 0; cyc = 1;
    while (!got_done && cyc < 60) begin
      re_cnt += int'(mem_re);
      if (instr_vld && lat == 0) lat = cyc;
      if (instr_vld && instr_rdy) begin
        epc = first + 12'(k);
        chk({tag, "_pc"}, 32'(instr_pc), 32'(epc));
        chk({tag, "_instr"}, 32'(instr), {16'h0, 4'h5, epc});
        k++;
      end
      if (done) begin
        got_done = 1;
      end else begin
        step();
        start = 1'b0;
        cyc++;
      end
    end
    chk({tag, "_done_seen"}, 32'(got_done), 32'd1);
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int k, dn, re, lat, i;
    rst = 1'b1; start = 1'b0; abort = 1'b0; instr_rdy = 1'b0;
    start_addr = '0; end_addr = '0;
    step(); step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_mem_re", 32'(mem_re), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_vld", 32'(instr_vld), 0);
    chk("rst_instr", 32'(instr), 0);
    chk("rst_pc", 32'(instr_pc), 0);
    rst = 1'b0;
    step();
    chk("idle_busy", 32'(busy), 0);

    // Basic run 0x10..0x13 with decoder always ready.
    start = 1'b1; start_addr = 12'h010; end_addr = 12'h013; instr_rdy = 1'b1;
    step(); start = 1'b0;
    chk("t1_busy", 32'(busy), 1);
    chk("t1_mem_addr0", 32'(mem_addr), 32'h010);
    collect("t1", 12'h010, k, dn, re, lat);
    chk("t1_count", 32'(k), 4);
    chk("t1_reads", 32'(re), 4);
    chk("t1_latency", 32'(lat), 3);
    step();
    chk("t1_done_pulse", 32'(done), 0);

    // Same run with 10 stalled cycles after the first valid.
    start = 1'b1; instr_rdy = 1'b0;
    step(); start = 1'b0;
    re = 0; i = 0;
    while (!instr_vld && i < 10) begin
      re += int'(mem_re);
      step();
      i++;
    end
    chk("t2_latency", 32'(i + 1), 3);
    for (int c = 0; c < 10; c++) begin
      re += int'(mem_re);
      chk("t2_hold_vld", 32'(instr_vld), 1);
      chk("t2_hold_pc", 32'(instr_pc), 32'h010);
      chk("t2_hold_instr", 32'(instr), 32'h5010);
      step();
    end
    chk("t2_reads_during_stall", 32'(re), 4);
    instr_rdy = 1'b1;
    collect("t2", 12'h010, k, dn, re, lat);
    chk("t2_count", 32'(k), 4);
    chk("t2_reads_after", 32'(re), 0);
    step();

    // Address wrap: FFE..001.
    start = 1'b1; start_addr = 12'hFFE; end_addr = 12'h001;
    step(); start = 1'b0;
    collect("t3", 12'hFFE, k, dn, re, lat);
    chk("t3_count", 32'(k), 4);
    chk("t3_reads", 32'(re), 4);
    step();

    // Single instruction; a second start while busy must be ignored.
    start = 1'b1; start_addr = 12'h020; end_addr = 12'h020;
    step();
    start = 1'b1; start_addr = 12'h050; end_addr = 12'h060;
    collect("t4", 12'h020, k, dn, re, lat);
    chk("t4_count", 32'(k), 1);
    chk("t4_reads", 32'(re), 1);
    step();
    chk("t4_idle_busy", 32'(busy), 0);
    step();
    chk("t4_idle_re", 32'(mem_re), 0);

    // start with abort in the same cycle: abort wins.
    start = 1'b1; abort = 1'b1; start_addr = 12'h030; end_addr = 12'h037;
    step(); start = 1'b0; abort = 1'b0;
    chk("t5_start_abort_busy", 32'(busy), 0);

    // Abort with one read in flight and two FIFO entries.
    instr_rdy = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    step(); step(); step();
    chk("t5_pre_vld", 32'(instr_vld), 1);
    chk("t5_pre_pc", 32'(instr_pc), 32'h030);
    abort = 1'b1;
    step(); abort = 1'b0;
    chk("t5_vld", 32'(instr_vld), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_done", 32'(done), 0);
    step();
    chk("t5_done_late", 32'(done), 0);
    chk("t5_vld_late", 32'(instr_vld), 0);
    start = 1'b1; start_addr = 12'h040; end_addr = 12'h041; instr_rdy = 1'b1;
    step(); start = 1'b0;
    collect("t5b", 12'h040, k, dn, re, lat);
    chk("t5b_count", 32'(k), 2);
    step();

    // Asynchronous reset mid-FETCH.
    start = 1'b1; start_addr = 12'h010; end_addr = 12'h017;
    step(); start = 1'b0;
    step(); step();
    chk("t6_pre_vld", 32'(instr_vld), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_busy", 32'(busy), 0);
    chk("t6_mem_re", 32'(mem_re), 0);
    chk("t6_mem_addr", 32'(mem_addr), 0);
    chk("t6_vld", 32'(instr_vld), 0);
    chk("t6_instr", 32'(instr), 0);
    chk("t6_pc", 32'(instr_pc), 0);
    chk("t6_done", 32'(done), 0);
    step(); step();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t6_post_busy", 32'(busy), 0);
      chk("t6_post_re", 32'(mem_re), 0);
      chk("t6_post_vld", 32'(instr_vld), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
